// File: rtl/funcg_sweeper.sv
// Exhaustive sweeper around the combinational funcG block: drives every {A,B,C,D}
// vector, samples g after a settle delay, and grades the captured truth table.
module funcg_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'hFF7C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        g_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_cnt,
    output logic        match
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] settle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            abcd         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            match        <= 1'b0;
            idx          <= '0;
            settle_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        table_out    <= '0;
                        mismatch_cnt <= '0;
                        match        <= 1'b0;
                        idx          <= '0;
                        settle_cnt   <= '0;
                        abcd         <= '0;
                        busy         <= 1'b1;
                        state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        abcd  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        abcd  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        table_out[idx] <= g_in;
                        if (g_in != EXPECTED[idx])
                            mismatch_cnt <= mismatch_cnt + 5'd1;
                        // abcd parks at 0 once the last vector has been sampled
                        if (idx == 4'd15) begin
                            abcd  <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx        <= idx + 4'd1;
                            abcd       <= idx + 4'd1;
                            settle_cnt <= '0;
                            state      <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    match <= (mismatch_cnt == 5'd0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_funcg_sweeper.sv
// Scoreboard bench for funcg_sweeper: predicted tables are queued at start and
// compared when the done pulse arrives.
module tb_funcg_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, start1 = 1'b0;
    logic        g_in, g_in1;
    logic [3:0]  abcd, abcd1;
    logic        busy, done, match, busy1, done1, match1;
    logic [15:0] table_out, table_out1;
    logic [4:0]  mismatch_cnt, mismatch_cnt1;
    int          mode = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic        m;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // mode 0: real funcG, 1: stuck 0, 2: stuck 1, 3: funcG with bit 5 inverted
    function automatic logic model(input logic [3:0] v, input int m);
        logic g;
        g = v[3] | (v[2] ^ v[1]) | (v[1] & ~v[0]);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (v == 4'd5) ? ~g : g;
            default: return g;
        endcase
    endfunction

    assign g_in  = model(abcd, mode);
    assign g_in1 = model(abcd1, 0);

    funcg_sweeper dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .g_in(g_in),
        .abcd(abcd), .busy(busy), .done(done), .table_out(table_out),
        .mismatch_cnt(mismatch_cnt), .match(match)
    );

    funcg_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .g_in(g_in1),
        .abcd(abcd1), .busy(busy1), .done(done1), .table_out(table_out1),
        .mismatch_cnt(mismatch_cnt1), .match(match1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t predict(input int m);
        exp_t e;
        e.tbl = '0;
        e.cnt = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            e.tbl[i] = model(4'(i), m);
            if (e.tbl[i] != model(4'(i), 0)) e.cnt = e.cnt + 5'd1;
        end
        e.m = (e.cnt == 5'd0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sweep; caller is at posedge+#1 with the DUT idle.
    task automatic sweep(input int m, input bit sel, input bit extra);
        int          per;
        int          done_cyc;
        int          pulses;
        logic [3:0]  a;
        logic        d, b, mt;
        logic [15:0] t;
        logic [4:0]  c;
        exp_t        e;
        per      = sel ? 2 : 3;
        done_cyc = 16 * per + 1;
        pulses   = 0;
        mode     = m;
        sb.push_back(predict(m));
        if (sel) start1 = 1'b1; else start = 1'b1;
        for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
            step();
            start  = 1'b0;
            start1 = 1'b0;
            a  = sel ? abcd1 : abcd;
            d  = sel ? done1 : done;
            b  = sel ? busy1 : busy;
            t  = sel ? table_out1 : table_out;
            c  = sel ? mismatch_cnt1 : mismatch_cnt;
            mt = sel ? match1 : match;
            if (d) pulses++;
            if (cyc == 1) begin
                check_eq("cleared_table", 32'(t), 32'h0);
                check_eq("cleared_cnt", 32'(c), 32'h0);
                check_eq("cleared_match", 32'(mt), 32'h0);
            end
            if (cyc < done_cyc) begin
                check_eq("abcd_seq", 32'(a), 32'((cyc - 1) / per));
                check_eq("busy_run", 32'(b), 32'h1);
            end
            if (cyc == done_cyc) begin
                check_eq("done_at_cycle", 32'(d), 32'h1);
                check_eq("busy_in_done", 32'(b), 32'h1);
                if (sb.size() == 0) begin
                    check_eq("sb_nonempty", 32'h0, 32'h1);
                end else begin
                    e = sb.pop_front();
                    check_eq("table_out", 32'(t), 32'(e.tbl));
                    check_eq("mismatch_cnt", 32'(c), 32'(e.cnt));
                end
            end
            if (cyc == done_cyc + 1) begin
                check_eq("match", 32'(mt), 32'(e.m));
                check_eq("busy_idle", 32'(b), 32'h0);
                check_eq("table_held", 32'(t), 32'(e.tbl));
            end
            if (extra && (cyc == 10 || cyc == 49)) start = 1'b1;
        end
        check_eq("done_pulses", 32'(pulses), 32'h1);
    endtask

    initial begin
        int guard;
        int pulses;
        #12;
        check_eq("rst_abcd", 32'(abcd), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_table", 32'(table_out), 32'h0);
        check_eq("rst_cnt", 32'(mismatch_cnt), 32'h0);
        check_eq("rst_match", 32'(match), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        sweep(0, 1'b0, 1'b0);
        sweep(1, 1'b0, 1'b0);
        sweep(2, 1'b0, 1'b1);
        sweep(3, 1'b0, 1'b0);

        // Abort when vector 6 first appears
        mode  = 0;
        start = 1'b1;
        guard = 0;
        step();
        start = 1'b0;
        while (abcd != 4'd6 && guard < 100) begin
            step();
            guard++;
        end
        check_eq("reach_abcd6", 32'(abcd), 32'h6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_abcd", 32'(abcd), 32'h0);
        check_eq("abort_table", 32'(table_out), 32'h003C);
        check_eq("abort_cnt", 32'(mismatch_cnt), 32'h0);
        check_eq("abort_match", 32'(match), 32'h0);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done) pulses++;
        end
        check_eq("abort_no_done", 32'(pulses), 32'h0);

        // abort together with start in IDLE must not launch a sweep
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        check_eq("abort_wins_busy", 32'(busy), 32'h0);
        check_eq("abort_wins_table", 32'(table_out), 32'h003C);

        // Asynchronous reset in the middle of vector 9
        start = 1'b1;
        guard = 0;
        step();
        start = 1'b0;
        while (abcd != 4'd9 && guard < 100) begin
            step();
            guard++;
        end
        check_eq("reach_abcd9", 32'(abcd), 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_abcd", 32'(abcd), 32'h0);
        check_eq("arst_busy", 32'(busy), 32'h0);
        check_eq("arst_table", 32'(table_out), 32'h0);
        check_eq("arst_cnt", 32'(mismatch_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        sweep(0, 1'b1, 1'b0);
        check_eq("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
